// File: rtl/blocks_to_hdmi_stream_if.sv
// Block-stream input and raster HDMI-style output bundle for blocks_to_hdmi_stream.
// Optional member hdmi_underflow exists only when BLOCKS_TO_HDMI_UNDERFLOW_EN is defined.
interface blocks_to_hdmi_stream_if #(
   parameter int N = 2
);
   logic           blk_valid;
   logic [N*8-1:0] blk_data_y;
   logic [N*8-1:0] blk_data_cr;
   logic [N*8-1:0] blk_data_cb;
   logic           blk_eob;
   logic           blk_sob;
   logic           blk_sof;

   logic           hdmi_v_sync;
   logic           hdmi_h_sync;
   logic           hdmi_data_valid;
   logic [N*8-1:0] hdmi_data_y;
   logic [N*8-1:0] hdmi_data_cr;
   logic [N*8-1:0] hdmi_data_cb;
`ifdef BLOCKS_TO_HDMI_UNDERFLOW_EN
   logic           hdmi_underflow;
`endif

   modport master (
      output blk_valid, blk_data_y, blk_data_cr, blk_data_cb,
      output blk_eob, blk_sob, blk_sof,
`ifdef BLOCKS_TO_HDMI_UNDERFLOW_EN
      input  hdmi_underflow,
`endif
      input  hdmi_v_sync, hdmi_h_sync, hdmi_data_valid,
      input  hdmi_data_y, hdmi_data_cr, hdmi_data_cb
   );

   modport slave (
      input  blk_valid, blk_data_y, blk_data_cr, blk_data_cb,
      input  blk_eob, blk_sob, blk_sof,
`ifdef BLOCKS_TO_HDMI_UNDERFLOW_EN
      output hdmi_underflow,
`endif
      output hdmi_v_sync, hdmi_h_sync, hdmi_data_valid,
      output hdmi_data_y, hdmi_data_cr, hdmi_data_cb
   );
endinterface

// File: rtl/blocks_to_hdmi_stream.sv
// 8x8 YCrCb block stream to raster video via a two-bank (ping-pong) block-row buffer.
// Optional sticky underflow flag: define BLOCKS_TO_HDMI_UNDERFLOW_EN.
module blocks_to_hdmi_stream #(
   parameter int N      = 2,
   parameter int X_RES  = 2160,
   parameter int Y_RES  = 1200,
   parameter int H_FP   = 40,
   parameter int H_SYNC = 20,
   parameter int H_BP   = 46,
   parameter int V_FP   = 28,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   blocks_to_hdmi_stream_if.slave bus_io
);
   localparam int BPL   = X_RES / N;
   localparam int BPR   = 8 / N;
   localparam int BPB   = 64 / N;
   localparam int NCOL  = X_RES / 8;
   localparam int NROW  = Y_RES / 8;
   localparam int HTOT  = BPL + H_FP + H_SYNC + H_BP;
   localparam int VTOT  = Y_RES + V_FP + V_SYNC + V_BP;
   localparam int DEPTH = 16 * BPL;
   localparam int BW    = (BPB > 1) ? $clog2(BPB) : 1;
   localparam int CW    = (NCOL > 1) ? $clog2(NCOL) : 1;
   localparam int RW    = (NROW > 1) ? $clog2(NROW) : 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int HW    = $clog2(HTOT);
   localparam int VW    = $clog2(VTOT);
   localparam int DW    = 24 * N;

   typedef enum logic {IDLE, RUN} state_t;

   logic [BW-1:0] beat_q, beat_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          wbank_q, wbank_d;
   logic          sofSeen_q, sofSeen_d;
   logic [1:0]    full_q, full_d;

   int            beatEff, colEff, rowEff;
   logic          wrBank;
   logic          rowFull;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   state_t        state_q;
   logic [HW-1:0] h_q;
   logic [VW-1:0] v_q;
   logic          rbank_q;
   logic          valid_q, hsync_q, vsync_q;
   logic [8*N-1:0] y_q, cr_q, cb_q;

   logic          beatActive;
   logic          rowRead;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;

   logic [DW-1:0] mem [DEPTH];

   // sob/sof override the stored counters on the very beat they arrive
   always_comb begin
      beatEff   = bus_io.blk_sob ? 0 : int'(beat_q);
      colEff    = bus_io.blk_sof ? 0 : int'(col_q);
      rowEff    = bus_io.blk_sof ? 0 : int'(row_q);
      wrBank    = bus_io.blk_sof ? 1'b0 : wbank_q;
      beat_d    = beat_q;
      col_d     = col_q;
      row_d     = row_q;
      wbank_d   = wbank_q;
      sofSeen_d = sofSeen_q | (bus_io.blk_valid & bus_io.blk_sof);
      rowFull   = 1'b0;
      wen       = bus_io.blk_valid;
      wdata     = {bus_io.blk_data_y, bus_io.blk_data_cr, bus_io.blk_data_cb};
      waddr     = AW'((wrBank ? 8 * BPL : 0) + (beatEff / BPR) * BPL
                      + colEff * BPR + (beatEff % BPR));
      if (bus_io.blk_valid) begin
         row_d   = RW'(rowEff);
         wbank_d = wrBank;
         if (bus_io.blk_eob) begin
            beat_d = '0;
            if (colEff == NCOL - 1) begin
               rowFull = 1'b1;
               col_d   = '0;
               wbank_d = ~wrBank;
               row_d   = (rowEff == NROW - 1) ? '0 : RW'(rowEff + 1);
            end else begin
               col_d = CW'(colEff + 1);
            end
         end else begin
            beat_d = BW'(beatEff + 1);
            col_d  = CW'(colEff);
         end
      end
   end

   // A write completing a row wins over a read release of the same bank
   always_comb begin
      full_d = full_q;
      if (rowRead) full_d[rbank_q] = 1'b0;
      if (rowFull) full_d[wrBank]  = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q    <= '0;
         col_q     <= '0;
         row_q     <= '0;
         wbank_q   <= 1'b0;
         sofSeen_q <= 1'b0;
         full_q    <= '0;
      end else begin
         beat_q    <= beat_d;
         col_q     <= col_d;
         row_q     <= row_d;
         wbank_q   <= wbank_d;
         sofSeen_q <= sofSeen_d;
         full_q    <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wen) mem[waddr] <= wdata;
   end

   assign beatActive = (state_q == RUN) && (int'(h_q) < BPL) && (int'(v_q) < Y_RES);
   assign rowRead    = beatActive && (int'(h_q) == BPL - 1) && (v_q[2:0] == 3'd7);
   assign raddr      = AW'((rbank_q ? 8 * BPL : 0) + int'(v_q[2:0]) * BPL + int'(h_q));
   assign rdata      = mem[raddr];

   // Timing generator: counters name the beat whose output appears one clock later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         h_q     <= '0;
         v_q     <= '0;
         rbank_q <= 1'b0;
         valid_q <= 1'b0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         y_q     <= '0;
         cr_q    <= '0;
         cb_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               h_q <= '0;
               v_q <= '0;
               if (sofSeen_q && full_q[rbank_q]) state_q <= RUN;
            end
            RUN: begin
               if (h_q == HW'(HTOT - 1)) begin
                  h_q <= '0;
                  v_q <= (v_q == VW'(VTOT - 1)) ? '0 : v_q + 1'b1;
               end else begin
                  h_q <= h_q + 1'b1;
               end
               if (rowRead) rbank_q <= ~rbank_q;
            end
         endcase
         valid_q <= beatActive;
         y_q     <= beatActive ? rdata[DW-1 -: 8*N]    : '0;
         cr_q    <= beatActive ? rdata[16*N-1 -: 8*N]  : '0;
         cb_q    <= beatActive ? rdata[8*N-1:0]        : '0;
         hsync_q <= (state_q == RUN) && (int'(h_q) >= BPL + H_FP)
                    && (int'(h_q) < BPL + H_FP + H_SYNC);
         vsync_q <= (state_q == RUN) && (int'(v_q) >= Y_RES + V_FP)
                    && (int'(v_q) < Y_RES + V_FP + V_SYNC);
      end
   end

`ifdef BLOCKS_TO_HDMI_UNDERFLOW_EN
   logic underflow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underflow_q <= 1'b0;
      end else if (beatActive && (h_q == '0) && (v_q[2:0] == 3'd0) && !full_q[rbank_q]) begin
         underflow_q <= 1'b1;
      end
   end

   assign bus_io.hdmi_underflow = underflow_q;
`endif

   assign bus_io.hdmi_v_sync     = vsync_q;
   assign bus_io.hdmi_h_sync     = hsync_q;
   assign bus_io.hdmi_data_valid = valid_q;
   assign bus_io.hdmi_data_y     = y_q;
   assign bus_io.hdmi_data_cr    = cr_q;
   assign bus_io.hdmi_data_cb    = cb_q;
endmodule

// File: tb/tb_blocks_to_hdmi_stream.sv
// Scoreboard bench for blocks_to_hdmi_stream on a reduced 16x16 raster.
// Define BLOCKS_TO_HDMI_UNDERFLOW_EN to also exercise the sticky underflow flag.
module tb_blocks_to_hdmi_stream;
   localparam int N      = 2;
   localparam int X_RES  = 16;
   localparam int Y_RES  = 16;
   localparam int H_FP   = 3;
   localparam int H_SYNC = 2;
   localparam int H_BP   = 2;
   localparam int V_FP   = 2;
   localparam int V_SYNC = 1;
   localparam int V_BP   = 1;
   localparam int BPL    = 8;
   localparam int HTOT   = 15;
   localparam int VTOT   = 20;
   localparam int FRAME  = HTOT * VTOT;

   typedef logic [24*N-1:0] beat_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    cyc = 0;
   int    testsRun = 0;
   int    testsFailed = 0;
   beat_t sb[$];
   bit    checkIdle = 1'b0;
   bit    timingArmed = 1'b0;
   bit    dataOn = 1'b1;
   int    startCyc = -1;
   int    lastEobCyc = -1;

   blocks_to_hdmi_stream_if #(.N(N)) bus ();

   blocks_to_hdmi_stream #(
      .N(N), .X_RES(X_RES), .Y_RES(Y_RES),
      .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus_io(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pixY(int f, int x, int yy);
      return 8'(f * 64 + yy * 16 + x);
   endfunction

   function automatic logic [7:0] pixCr(int f, int x, int yy);
      return pixY(f, x, yy) ^ 8'hA5;
   endfunction

   function automatic logic [7:0] pixCb(int f, int x, int yy);
      return 8'(pixY(f, x, yy) + 8'd77);
   endfunction

   task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic reportFail(string name, string what);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   // Expected raster beats of one block-row, in output order
   task automatic pushRow(int f, int r);
      logic [8*N-1:0] ly, lcr, lcb;
      for (int line = 0; line < 8; line++) begin
         for (int k = 0; k < BPL; k++) begin
            for (int i = 0; i < N; i++) begin
               ly[i*8 +: 8]  = pixY(f, k * N + i, 8 * r + line);
               lcr[i*8 +: 8] = pixCr(f, k * N + i, 8 * r + line);
               lcb[i*8 +: 8] = pixCb(f, k * N + i, 8 * r + line);
            end
            sb.push_back({ly, lcr, lcb});
         end
      end
   endtask

   task automatic driveIdle(bit junk);
      bus.blk_valid   = 1'b0;
      bus.blk_data_y  = junk ? {N{8'hEE}} : '0;
      bus.blk_data_cr = junk ? {N{8'hEE}} : '0;
      bus.blk_data_cb = junk ? {N{8'hEE}} : '0;
      bus.blk_sob     = junk;
      bus.blk_eob     = junk;
      bus.blk_sof     = junk;
   endtask

   task automatic applyStimulus(int f, int r, bit withSof, int gapEvery, int nBlocks);
      for (int c = 0; c < nBlocks; c++) begin
         for (int b = 0; b < 32; b++) begin
            if (gapEvery > 0 && (b % gapEvery) == gapEvery - 1) begin
               driveIdle(1'b1);
               @(posedge clk); #1;
            end
            for (int i = 0; i < N; i++) begin
               bus.blk_data_y[i*8 +: 8]  = pixY(f, 8 * c + (b % 4) * 2 + i, 8 * r + b / 4);
               bus.blk_data_cr[i*8 +: 8] = pixCr(f, 8 * c + (b % 4) * 2 + i, 8 * r + b / 4);
               bus.blk_data_cb[i*8 +: 8] = pixCb(f, 8 * c + (b % 4) * 2 + i, 8 * r + b / 4);
            end
            bus.blk_valid = 1'b1;
            bus.blk_sob   = (b == 0);
            bus.blk_eob   = (b == 31);
            bus.blk_sof   = withSof && (c == 0) && (b == 0);
            @(posedge clk); #1;
            if (b == 31) lastEobCyc = cyc;
         end
      end
      driveIdle(1'b0);
   endtask

   task automatic waitCyc(int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic waitStart(int bound);
      for (int i = 0; i < bound && startCyc < 0; i++) begin
         @(posedge clk); #1;
      end
      if (startCyc < 0) reportFail("first_valid", "no valid beat within bound, required one");
   endtask

   // Monitor: idle checks, raster timing model and scoreboard pops
   initial begin : monitor
      int    p, line, bt;
      beat_t e;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            if (checkIdle) begin
               checkOutput("idle_outputs",
                  {bus.hdmi_data_valid, bus.hdmi_h_sync, bus.hdmi_v_sync,
                   bus.hdmi_data_y, bus.hdmi_data_cr, bus.hdmi_data_cb}, '0);
            end else if (timingArmed) begin
               if (startCyc < 0 && bus.hdmi_data_valid) begin
                  startCyc = cyc;
                  checkOutput("first_valid_latency", 128'(cyc - lastEobCyc), 128'(2));
               end
               if (startCyc >= 0) begin
                  p    = (cyc - startCyc) % FRAME;
                  line = p / HTOT;
                  bt   = p % HTOT;
                  checkOutput("sync_timing",
                     {bus.hdmi_data_valid, bus.hdmi_h_sync, bus.hdmi_v_sync},
                     {(line < Y_RES) && (bt < BPL),
                      (bt >= BPL + H_FP) && (bt < BPL + H_FP + H_SYNC),
                      (line >= Y_RES + V_FP) && (line < Y_RES + V_FP + V_SYNC)});
               end
               if (!bus.hdmi_data_valid) begin
                  checkOutput("blank_data",
                     {bus.hdmi_data_y, bus.hdmi_data_cr, bus.hdmi_data_cb}, '0);
               end else if (dataOn) begin
                  if (sb.size() == 0) begin
                     reportFail("unexpected_valid", "valid beat with empty scoreboard, required none");
                  end else begin
                     e = sb.pop_front();
                     checkOutput("pixel_data",
                        {bus.hdmi_data_y, bus.hdmi_data_cr, bus.hdmi_data_cb}, e);
                  end
               end
            end
         end
      end
   end

   initial begin : stim
      driveIdle(1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state",
         {bus.hdmi_data_valid, bus.hdmi_h_sync, bus.hdmi_v_sync,
          bus.hdmi_data_y, bus.hdmi_data_cr, bus.hdmi_data_cb}, '0);
      @(negedge clk) rst = 1'b0;

      // Start a frame, then hit reset while active pixels are streaming
      timingArmed = 1'b1;
      pushRow(0, 0);
      applyStimulus(0, 0, 1'b1, 0, 2);
      waitStart(20);
      waitCyc(startCyc + 3);
      @(negedge clk) rst = 1'b1;
      #1;
      checkOutput("async_reset",
         {bus.hdmi_data_valid, bus.hdmi_h_sync, bus.hdmi_v_sync,
          bus.hdmi_data_y, bus.hdmi_data_cr, bus.hdmi_data_cb}, '0);
      timingArmed = 1'b0;
      startCyc    = -1;
      sb.delete();
      @(negedge clk) rst = 1'b0;

      // Half a block-row after sof must not start the timing generator
      checkIdle = 1'b1;
      applyStimulus(0, 0, 1'b1, 0, 1);
      repeat (40) @(posedge clk);
      #1;
      checkIdle = 1'b0;

      // Two frames; second frame's last block-row arrives with valid gaps
      timingArmed = 1'b1;
      pushRow(0, 0);
      applyStimulus(0, 0, 1'b1, 0, 2);
      waitStart(20);
      pushRow(0, 1);
      applyStimulus(0, 1, 1'b0, 0, 2);
      waitCyc(startCyc + 150);
      pushRow(1, 0);
      applyStimulus(1, 0, 1'b1, 0, 2);
      waitCyc(startCyc + 250);
      pushRow(1, 1);
      applyStimulus(1, 1, 1'b0, 5, 2);
      while (sb.size() != 0 && cyc < startCyc + 700) begin
         @(posedge clk); #1;
      end
      if (sb.size() != 0) reportFail("drain", $sformatf("%0d beats never output, required 0", sb.size()));
      waitCyc(startCyc + 595);

`ifdef BLOCKS_TO_HDMI_UNDERFLOW_EN
      checkOutput("no_underflow", 128'(bus.hdmi_underflow), 128'(0));
      dataOn = 1'b0;
      waitCyc(startCyc + 610);
      checkOutput("underflow_set", 128'(bus.hdmi_underflow), 128'(1));
      waitCyc(startCyc + 700);
      checkOutput("underflow_sticky", 128'(bus.hdmi_underflow), 128'(1));
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/blocks_to_hdmi_stream.md
Name: blocks_to_hdmi_stream

Overview:
Converts a stream of 8x8 pixel blocks (YCrCb, N pixels per beat, raster block order) into a raster HDMI-style video stream with h/v sync and blanking. Sits between the JPEG block decoder and the HDMI transmitter interface. A ping-pong buffer holds two 8-line block-rows. A free-running timing generator reads one bank while the other is written.

Parameters:
N, 2, pixels per beat on both sides; must divide 8
X_RES, 2160, active pixels per line; multiple of 8 and of N
Y_RES, 1200, active lines per frame; multiple of 8
H_FP, 40, horizontal front porch, beats
H_SYNC, 20, horizontal sync width, beats
H_BP, 46, horizontal back porch, beats
V_FP, 28, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 24, vertical back porch, lines

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
hdmi_v_sync  out  1  vertical sync, active high
hdmi_h_sync  out  1  horizontal sync, active high
hdmi_data_valid  out  1  active-video beat
hdmi_data_y  out  N x 8 signed  luma; lane i = pixel x = beat*N+i
hdmi_data_cr  out  N x 8 signed  Cr, same lane mapping
hdmi_data_cb  out  N x 8 signed  Cb, same lane mapping
blk_valid  in  1  input beat qualifier
blk_data_y  in  N x 8 signed  block luma beat
blk_data_cr  in  N x 8 signed  block Cr beat
blk_data_cb  in  N x 8 signed  block Cb beat
blk_eob  in  1  last beat of block (beat 64/N-1)
blk_sob  in  1  first beat of block
blk_sof  in  1  first beat of frame (with blk_sob)

Behaviour:
- Reset: all outputs 0; write counters 0; both banks empty; timing generator IDLE.
- Input accepted only when blk_valid=1; no backpressure. Each block has 64/N beats. Beat b maps to block row b/(8/N) and column (b mod (8/N))*N. Lane i is the pixel at column+i.
- blk_sob resets the beat counter to 0. blk_sof also resets the block-column and block-row counters to 0 and selects write bank 0.
- Block column c occupies x = 8c..8c+7. After X_RES/8 blocks, the write bank is marked full, the write bank toggles, and the block-row counter increments. It wraps at Y_RES/8.
- Timing generator states: IDLE and RUN. Exits IDLE when bank 0 becomes full after an sof. Line 0 first valid beat occurs exactly 2 clk after the edge that sampled the final eob of block-row 0.
- Line order: X_RES/N active beats, then H_FP, H_SYNC (h_sync=1), H_BP. Frame order: Y_RES active lines, then V_FP, V_SYNC (v_sync=1 for whole lines), V_BP blank lines.
- h_sync continues during vertical blanking. RUN free-runs frame to frame; only rst returns it to IDLE.
- Every 8 active lines the read bank toggles and the bank just read is marked empty.
- During blanking, hdmi_data_* = 0 and hdmi_data_valid = 0.
- Input rate matches output rate (8 lines of active data per 8 line periods), so no overflow with conforming input.
- If a bank is not full when its first line starts (underflow), stale bank contents are output and timing is unaffected.
- blk_sof mid-frame: write counters resync; timing generator unaffected.
- Simultaneous bank-full (write) and bank-empty (read) events on the same cycle on different banks: both apply.
- All outputs registered.

Optional Feature:
Macro BLOCKS_TO_HDMI_UNDERFLOW_EN.
- Defined: adds output hdmi_underflow (1 bit). It is set sticky when a read bank is not full at the start of its first line. Cleared only by rst.
- Not defined: port absent; underflow undetected, behaviour otherwise identical.

Test Plan:
- Reset: rst=1 mid-stream -> all outputs 0 immediately; after release, no valid until a full block-row is received after sof.
- Single frame, defaults, incrementing data per beat, block-row 0 sent contiguously -> valid asserts 2 clk after last eob. Line 0 lane0 Y equals beat 0 value of block 0, lane1 equals that value +0 (same beat). Beats 4..7 of line 0 come from block 1.
- Line timing -> 1080 valid beats, 40 blank, 20 h_sync, 46 blank; period 1186 clk on every line.
- Frame timing -> 1200 active lines, 28 blank lines, 2 lines with v_sync=1, 24 blank lines; next frame line 0 follows seamlessly.
- blk_valid gaps inside a block -> output identical to gapless input.
- Underflow (macro defined): stall block-row 1 beyond line 8 start -> hdmi_underflow=1 and stays 1; sync timing unchanged.
